// File: rtl/core_pkg.sv
// Shared encodings for the RV32 multi-cycle core: sequencer states, mux selects
// and trap causes.
package core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1,
    PC_ALU   = 2'd2
  } pc_sel_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2
  } wb_sel_t;

  typedef enum logic [1:0] {
    CAUSE_ILLEGAL = 2'd0,
    CAUSE_IMEM_TO = 2'd1,
    CAUSE_DMEM_TO = 2'd2
  } trap_cause_t;

endpackage

// File: rtl/ctrl_perf_cnt.sv
// Cycle and retired-instruction counters for core_ctrl; both wrap at 2^CNT_W.
module ctrl_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             active,
  input  logic             retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (active) cycle_cnt   <= cycle_cnt + CNT_W'(1);
      if (retire) instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/core_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory watchdog and trap.
// Define CORE_CTRL_PERF_CNT_EN to build the cycle/instret performance counters.
module core_ctrl
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             halt_req,
  input  logic             dec_reg_write,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_branch,
  input  logic             dec_jump,
  input  logic             dec_jalr,
  input  logic             branch_taken,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  // Watchdog only needs to reach TIMEOUT_CYC-1: the expiring cycle is the last not-ready one.
  localparam int unsigned     WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  state_t          st_q, st_d;
  trap_cause_t     cause_q, cause_d;
  logic [WD_W-1:0] wd_q;
  logic            wd_expire;
  logic            retire;

  assign wd_expire = (TIMEOUT_CYC != 0) && (wd_q == WD_LAST);

  always_comb begin
    st_d     = st_q;
    cause_d  = cause_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    rf_we    = 1'b0;
    pc_sel   = PC_PLUS4;
    wb_sel   = WB_ALU;
    retire   = 1'b0;
    case (st_q)
      ST_IDLE: if (!halt_req) st_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we = 1'b1;
          st_d  = ST_DECODE;
        end else if (wd_expire) begin
          st_d    = ST_TRAP;
          cause_d = CAUSE_IMEM_TO;
        end
      end
      ST_DECODE: begin
        if (!(dec_reg_write | dec_mem_read | dec_mem_write | dec_branch | dec_jump)) begin
          st_d    = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          st_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (dec_mem_read | dec_mem_write) begin
          st_d = ST_MEM;
        end else if (dec_branch) begin
          retire = 1'b1;
          pc_sel = branch_taken ? PC_IMM : PC_PLUS4;
        end else begin
          st_d = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_mem_write;
        if (dmem_ready) begin
          if (dec_mem_write) retire = 1'b1;
          else               st_d   = ST_WB;
        end else if (wd_expire) begin
          st_d    = ST_TRAP;
          cause_d = CAUSE_DMEM_TO;
        end
      end
      ST_WB: begin
        rf_we  = 1'b1;
        retire = 1'b1;
        if (dec_mem_read)               wb_sel = WB_LOAD;
        else if (dec_jump | dec_jalr)   wb_sel = WB_PC4;
        if (dec_jalr)                   pc_sel = PC_ALU;
        else if (dec_jump)              pc_sel = PC_IMM;
      end
      ST_TRAP: ;
      default: st_d = ST_IDLE;
    endcase
    // Every retire path shares the halt decision at the instruction boundary.
    if (retire) st_d = halt_req ? ST_IDLE : ST_FETCH;
  end

  assign pc_we = retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_IDLE;
      cause_q <= CAUSE_ILLEGAL;
    end else begin
      st_q    <= st_d;
      cause_q <= cause_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else if ((st_d == ST_FETCH && st_q != ST_FETCH) || (st_d == ST_MEM && st_q != ST_MEM)) begin
      wd_q <= '0;
    end else if ((imem_req && !imem_ready) || (dmem_req && !dmem_ready)) begin
      wd_q <= wd_q + WD_W'(1);
    end
  end

  assign trap       = (st_q == ST_TRAP);
  assign trap_cause = cause_q;
  assign halted     = (st_q == ST_IDLE);
  assign state      = st_q;

`ifdef CORE_CTRL_PERF_CNT_EN
  ctrl_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .active      (st_q != ST_IDLE && st_q != ST_TRAP),
    .retire      (retire),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule
